// File: rtl/cmp_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_sched_pkg
//  Description : Shared definitions for the compare scheduler: requester
//                count, operand width, FSM state encoding and the packed
//                {lt, eq, gt} result codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_sched_pkg;

    localparam int NUM_REQ = 4;    // number of requesters (fixed)
    localparam int W       = 2;    // operand width in bits (fixed)
    localparam int ID_W    = 2;    // width of a requester index
    localparam int CNT_W   = 8;    // completed-comparison counter width

    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Result codes, bit order {lt, eq, gt}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;

endpackage : cmp_sched_pkg
`default_nettype wire

// File: rtl/cmp2_core.sv
`default_nettype none
// ============================================================================
//  Module      : cmp2_core
//  Description : Purely combinational 2-bit unsigned magnitude comparator.
//  Ports       : a, b   - operands
//                lt     - a <  b
//                eq     - a == b
//                gt     - a >  b
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp2_core (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       lt,
    output logic       eq,
    output logic       gt
);

    assign lt = (a <  b);
    assign eq = (a == b);
    assign gt = (a >  b);

endmodule : cmp2_core
`default_nettype wire

// File: rtl/compare_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : compare_scheduler
//  Description : Round-robin arbiter in front of a shared 2-bit comparator.
//                One request is served per IDLE -> CMP -> RESP transaction;
//                the result is held until the consumer acknowledges it.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                req            - per-requester compare request
//                a_in, b_in     - packed operands, requester i on [2i+1:2i]
//                res_ack        - consumer accepts the current result
//                gnt            - one-hot pulse, winner's operands captured
//                busy           - FSM not in IDLE
//                res_valid      - result valid, held until accepted
//                res_id         - owner of the current result
//                lt, eq, gt     - unsigned compare outcome
//                cmp_count      - saturating count of acknowledged results
//  Revision    : 1.0 - initial release
// ============================================================================
module compare_scheduler
    import cmp_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] a_in,
    input  logic [NUM_REQ*W-1:0] b_in,
    input  logic                 res_ack,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 busy,
    output logic                 res_valid,
    output logic [ID_W-1:0]      res_id,
    output logic                 lt,
    output logic                 eq,
    output logic                 gt,
    output logic [CNT_W-1:0]     cmp_count
);

    localparam logic [NUM_REQ-1:0] c_gnt_lsb = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic [2:0]         r_result;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_busy;
    logic               r_res_valid;
    logic [ID_W-1:0]    r_res_id;
    logic [CNT_W-1:0]   r_cmp_count;

    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_win_id;
    logic               w_found;
    logic               w_lt;
    logic               w_eq;
    logic               w_gt;

    // Round-robin search starting at r_ptr; the index wraps naturally in
    // ID_W bits, so the first set request in ptr, ptr+1, ... order wins.
    always_comb begin
        w_idx    = '0;
        w_win_id = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = r_ptr + k[ID_W-1:0];
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_win_id = w_idx;
            end
        end
    end

    cmp2_core u_core (
        .a  (r_op_a),
        .b  (r_op_b),
        .lt (w_lt),
        .eq (w_eq),
        .gt (w_gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= RES_NONE;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_cmp_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_state  <= CMP;
                        r_op_a   <= a_in[w_win_id*W +: W];
                        r_op_b   <= b_in[w_win_id*W +: W];
                        r_res_id <= w_win_id;
                        r_gnt    <= c_gnt_lsb << w_win_id;
                        r_busy   <= 1'b1;
                    end
                end
                CMP: begin
                    r_state     <= RESP;
                    r_gnt       <= '0;
                    r_result    <= {w_lt, w_eq, w_gt};
                    r_res_valid <= 1'b1;
                end
                RESP: begin
                    if (res_ack) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_result    <= RES_NONE;
                        r_busy      <= 1'b0;
                        // Winner becomes lowest priority for the next search
                        r_ptr       <= r_res_id + 1'b1;
                        if (r_cmp_count != CNT_MAX) begin
                            r_cmp_count <= r_cmp_count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt       <= '0;
                    r_busy      <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_result    <= RES_NONE;
                end
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign busy         = r_busy;
    assign res_valid    = r_res_valid;
    assign res_id       = r_res_id;
    assign {lt, eq, gt} = r_result;
    assign cmp_count    = r_cmp_count;

endmodule : compare_scheduler
`default_nettype wire

// File: tb/tb_compare_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compare_scheduler
//  Description : Self-checking bench for compare_scheduler: table-driven
//                arbitration/compare vectors plus directed sequences for
//                held results, mid-transaction reset, rotation and counter
//                saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_compare_scheduler;
    import cmp_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       res_ack;
    logic [3:0] gnt;
    logic       busy;
    logic       res_valid;
    logic [1:0] res_id;
    logic       lt;
    logic       eq;
    logic       gt;
    logic [7:0] cmp_count;

    int errors    = 0;
    int checks    = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    compare_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .res_ack   (res_ack),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_id    (res_id),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt),
        .cmp_count (cmp_count)
    );

    typedef struct {
        logic [3:0] req;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] id;
        logic [2:0] res;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt),       32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_id"},    32'(res_id),    32'd0);
        check({tag, "_res"},   32'({lt, eq, gt}), 32'd0);
        check({tag, "_count"}, 32'(cmp_count), 32'd0);
    endtask

    // Starts in IDLE just after a rising edge. Operands are scrambled and
    // req dropped right after the grant to show the latched copy is used.
    task automatic run_txn(input logic [3:0] rq, input logic [7:0] av, input logic [7:0] bv,
                           input logic [1:0] id, input logic [2:0] res, input bit do_ack);
        req  = rq;
        a_in = av;
        b_in = bv;
        tick();
        check("gnt",       32'(gnt),       32'(4'b0001 << id));
        check("busy_cmp",  32'(busy),      32'd1);
        check("valid_cmp", 32'(res_valid), 32'd0);
        req  = 4'b0000;
        a_in = ~av;
        b_in = ~bv;
        tick();
        check("gnt_resp",  32'(gnt),       32'd0);
        check("valid",     32'(res_valid), 32'd1);
        check("res_id",    32'(res_id),    32'(id));
        check("result",    32'({lt, eq, gt}), 32'(res));
        check("onehot",    32'($countones({lt, eq, gt})), 32'd1);
        if (do_ack) begin
            res_ack = 1'b1;
            tick();
            res_ack = 1'b0;
            if (exp_count < 255) exp_count++;
            check("valid_clr", 32'(res_valid), 32'd0);
            check("busy_clr",  32'(busy),      32'd0);
            check("res_clr",   32'({lt, eq, gt}), 32'd0);
            check("count",     32'(cmp_count), 32'(exp_count));
        end
    endtask

    initial begin
        logic [1:0] av2;
        logic [1:0] bv2;
        logic [2:0] er;
        logic [1:0] hold_id;
        logic [2:0] hold_res;
        int n;

        vecs[0] = '{4'b0010, 8'h0C, 8'h07, 2'd1, RES_GT};
        vecs[1] = '{4'b0011, 8'h0C, 8'h02, 2'd0, RES_LT};
        vecs[2] = '{4'b0011, 8'h0B, 8'h08, 2'd1, RES_EQ};
        vecs[3] = '{4'b1001, 8'h43, 8'hC0, 2'd3, RES_LT};
        vecs[4] = '{4'b1100, 8'h30, 8'hC0, 2'd2, RES_GT};
        vecs[5] = '{4'b0111, 8'h0D, 8'h31, 2'd0, RES_EQ};
        vecs[6] = '{4'b1000, 8'h80, 8'h40, 2'd3, RES_GT};

        rst     = 1'b1;
        req     = 4'b0000;
        a_in    = 8'h00;
        b_in    = 8'h00;
        res_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Table-driven arbitration and compare vectors
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].id, vecs[i].res, 1'b1);
        end

        // All 16 operand pairs through requester 3
        for (int i = 0; i < 16; i++) begin
            av2 = i[3:2];
            bv2 = i[1:0];
            er  = (av2 < bv2) ? RES_LT : ((av2 == bv2) ? RES_EQ : RES_GT);
            run_txn(4'b1000, {av2, 6'b0}, {bv2, 6'b0}, 2'd3, er, 1'b1);
        end

        // Result held for 10 cycles without ack while others request
        hold_id  = 2'd0;
        hold_res = RES_LT;
        run_txn(4'b0001, 8'h01, 8'h02, hold_id, hold_res, 1'b0);
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_id",    32'(res_id),    32'(hold_id));
            check("hold_res",   32'({lt, eq, gt}), 32'(hold_res));
            check("hold_gnt",   32'(gnt),       32'd0);
            check("hold_busy",  32'(busy),      32'd1);
        end
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        req     = 4'b0000;
        exp_count++;
        check("hold_ack_valid", 32'(res_valid), 32'd0);
        check("hold_ack_busy",  32'(busy),      32'd0);
        check("hold_ack_count", 32'(cmp_count), 32'(exp_count));

        // Reset while in CMP
        req  = 4'b0100;
        a_in = 8'h30;
        b_in = 8'h00;
        tick();
        check("rstcmp_gnt", 32'(gnt), 32'h4);
        #1 rst = 1'b1;
        #1;
        check_all_zero("rst_in_cmp");
        exp_count = 0;
        @(negedge clk);
        rst  = 1'b0;
        req  = 4'b1111;
        a_in = 8'h00;
        b_in = 8'h00;
        tick();
        check("post_rst1_gnt", 32'(gnt), 32'h1);

        // Reset while in RESP
        tick();
        check("rstresp_valid", 32'(res_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_all_zero("rst_in_resp");
        @(negedge clk);
        rst  = 1'b0;
        a_in = 8'hE4;
        b_in = 8'hE4;
        tick();
        check("post_rst2_gnt",   32'(gnt),       32'h1);
        check("post_rst2_count", 32'(cmp_count), 32'd0);

        // Continuous requests with ack tied high: strict rotation
        res_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (gnt == 4'b0000 && n < 6) begin
                tick();
                n++;
            end
            check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            tick();
            check("rr_valid", 32'(res_valid), 32'd1);
            check("rr_eq",    32'({lt, eq, gt}), 32'(RES_EQ));
            check("rr_id",    32'(res_id),    32'(k % 4));
            tick();
            exp_count++;
            check("rr_count", 32'(cmp_count), 32'(exp_count));
        end

        // Run up to saturation, then one more ack must not wrap
        n = 0;
        while (cmp_count != 8'hFF && n < 1000) begin
            tick();
            n++;
        end
        check("sat_reach", 32'(cmp_count), 32'hFF);
        n = 0;
        while (res_valid == 1'b0 && n < 6) begin
            tick();
            n++;
        end
        check("sat_valid", 32'(res_valid), 32'd1);
        tick();
        check("sat_hold",  32'(cmp_count), 32'hFF);
        check("sat_idle",  32'(busy),      32'd0);
        req     = 4'b0000;
        res_ack = 1'b0;
        repeat (3) tick();
        check("sat_final", 32'(cmp_count), 32'hFF);
        check("idle_busy", 32'(busy),      32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_compare_scheduler
`default_nettype wire
